// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared FSM encoding and default register-file/accumulator widths
package reg_file_pkg;
  localparam int REG_BIT_CNT_D = 2;
  localparam int DATA_WIDTH_D = 8;
  typedef enum logic [1:0] {IDLE, WR, RD, LOAD} state_t;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: decode/accumulator bus (ld, st, sel, acc_in in; acc_out, acc_we, busy, done out); master = decode/acc side, slave = reg_file
interface reg_file_if import reg_file_pkg::*; #(
  parameter int REG_BIT_CNT = REG_BIT_CNT_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D
);
  logic ld;
  logic st;
  logic [REG_BIT_CNT-1:0] sel;
  logic [DATA_WIDTH-1:0] acc_in;
  logic [DATA_WIDTH-1:0] acc_out;
  logic acc_we;
  logic busy;
  logic done;
  modport master(output ld, st, sel, acc_in, input acc_out, acc_we, busy, done);
  modport slave(input ld, st, sel, acc_in, output acc_out, acc_we, busy, done);
endinterface

// File: rtl/rf_array.sv
// rf_array: register storage with one sync write port, one registered read port and sync active-low clear (clk, rst_n, we/waddr/wdata, re/raddr/rdata); RF_ZERO_R0_EN makes entry 0 read-only zero
module rf_array #(
  parameter int REG_BIT_CNT = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic we,
  input  logic [REG_BIT_CNT-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic re,
  input  logic [REG_BIT_CNT-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
`ifdef RF_ZERO_R0_EN
  // entry 0 is cleared by reset and never written, so it always reads zero
  wire wr_ok = waddr != '0;
`else
  wire wr_ok = 1'b1;
`endif
  logic [DATA_WIDTH-1:0] mem [2**REG_BIT_CNT];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**REG_BIT_CNT; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we && wr_ok) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
    end
  end
endmodule

// File: rtl/reg_file.sv
// reg_file: load/store sequencer over rf_array (clk, rst_n sync active-low, bus: reg_file_if.slave); honours RF_ZERO_R0_EN via rf_array
module reg_file import reg_file_pkg::*; #(
  parameter int REG_BIT_CNT = REG_BIT_CNT_D,
  parameter int DATA_WIDTH = DATA_WIDTH_D
) (
  input logic clk,
  input logic rst_n,
  reg_file_if.slave bus
);
  state_t state, state_nx;
  logic [REG_BIT_CNT-1:0] sel_q;
  logic [DATA_WIDTH-1:0] data_q;
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // operands latched on acceptance; acc_in changes during WR are irrelevant
  always_ff @(posedge clk) begin
    if (state == IDLE && (bus.st || bus.ld)) sel_q <= bus.sel;
    if (state == IDLE && bus.st) data_q <= bus.acc_in;
  end
  always_comb begin
    state_nx = state == IDLE ? (bus.st ? WR : bus.ld ? RD : IDLE) : state == RD ? LOAD : IDLE;
    bus.busy = state != IDLE;
    bus.done = state == WR || state == LOAD;
    bus.acc_we = state == LOAD;
  end
  rf_array #(.REG_BIT_CNT(REG_BIT_CNT), .DATA_WIDTH(DATA_WIDTH)) u_array (
    .clk(clk),
    .rst_n(rst_n),
    .we(state == WR),
    .waddr(sel_q),
    .wdata(data_q),
    .re(state == RD),
    .raddr(sel_q),
    .rdata(bus.acc_out)
  );
endmodule
